tt_sweep_capture: RTL and testbench

TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

---
 rtl/tt_sweep_capture_if.sv | 24 ++
 rtl/tt_sweep_capture.sv | 111 +++++++++++
 tb/tb_tt_sweep_capture.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_capture_if.sv
// Handshake and data bundle between the sweep/capture engine and its environment.
// Signal names follow the block's external pin names.
interface tt_sweep_capture_if;
    logic         start;
    logic [6:0]   x;
    logic         f;
    logic [127:0] expected;
    logic         busy;
    logic [127:0] tt_out;
    logic         tt_valid;
    logic         tt_ready;
    logic [7:0]   mismatch_cnt;
    logic         match;

    modport slave (
        input  start, f, expected, tt_ready,
        output x, busy, tt_out, tt_valid, mismatch_cnt, match
    );

    modport master (
        output start, f, expected, tt_ready,
        input  x, busy, tt_out, tt_valid, mismatch_cnt, match
    );
endinterface

// File: rtl/tt_sweep_capture.sv
// Sweeps a 7-input function over all 128 input codes, captures its truth table
// through a LAT-deep index delay line and counts disagreements with a reference.
module tt_sweep_capture #(
    parameter int LAT = 0
) (
    input logic             clk,
    input logic             rst,
    tt_sweep_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} state_t;

    state_t       r_state, w_state_nxt;
    logic [6:0]   r_x, w_x_nxt;
    logic [127:0] r_exp, r_tt;
    logic [7:0]   r_mm, w_mm_nxt;
    logic         r_busy, r_valid, r_match;
    logic         w_busy_nxt, w_valid_nxt, w_match_nxt;
    logic         w_cap_vld, w_cap_en, w_cap_err, w_accept;
    logic [6:0]   w_cap_idx;

    // Capture point: index i reaches the capture stage LAT cycles after x=i is driven.
    if (LAT == 0) begin : g_direct
        assign w_cap_vld = (r_state == SWEEP);
        assign w_cap_idx = r_x;
    end else begin : g_delay
        logic [LAT-1:0]      r_vld_pipe;
        logic [LAT-1:0][6:0] r_idx_pipe;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld_pipe <= '0;
                r_idx_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= (r_state == SWEEP);
                r_idx_pipe[0] <= r_x;
                for (int k = 1; k < LAT; k++) begin
                    r_vld_pipe[k] <= r_vld_pipe[k-1];
                    r_idx_pipe[k] <= r_idx_pipe[k-1];
                end
            end
        end

        assign w_cap_vld = r_vld_pipe[LAT-1];
        assign w_cap_idx = r_idx_pipe[LAT-1];
    end

    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_cap_en  = w_cap_vld && ((r_state == SWEEP) || (r_state == DRAIN));
    assign w_cap_err = w_cap_en && (bus.f != r_exp[w_cap_idx]);
    // At most 128 increments per sweep, so the 8-bit counter cannot wrap.
    assign w_mm_nxt  = w_accept ? 8'd0 : r_mm + {7'd0, w_cap_err};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SWEEP;
            SWEEP:   if (r_x == 7'd127) w_state_nxt = (LAT == 0) ? HOLD : DRAIN;
            DRAIN:   if (w_cap_vld && (w_cap_idx == 7'd127)) w_state_nxt = HOLD;
            HOLD:    if (bus.tt_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, decided from the upcoming state.
    always_comb begin
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_valid_nxt = (w_state_nxt == HOLD);
        w_match_nxt = (w_state_nxt == HOLD) && (w_mm_nxt == 8'd0);
        w_x_nxt     = 7'd0;
        if (w_state_nxt == DRAIN)
            w_x_nxt = 7'd127;
        else if ((w_state_nxt == SWEEP) && (r_state == SWEEP))
            w_x_nxt = r_x + 7'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_mm    <= '0;
            r_tt    <= '0;
            r_exp   <= '0;
        end else begin
            r_x     <= w_x_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_match <= w_match_nxt;
            r_mm    <= w_mm_nxt;
            if (w_accept) begin
                r_exp <= bus.expected;
                r_tt  <= '0;
            end else if (w_cap_en) begin
                r_tt[w_cap_idx] <= bus.f;
            end
        end
    end

    assign bus.x            = r_x;
    assign bus.busy         = r_busy;
    assign bus.tt_valid     = r_valid;
    assign bus.tt_out       = r_tt;
    assign bus.mismatch_cnt = r_mm;
    assign bus.match        = r_match;
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture at LAT=0 and LAT=3 with a result scoreboard.
module tb_tt_sweep_capture;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_sweep_capture_if b0();
    tt_sweep_capture_if b3();

    tt_sweep_capture #(.LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    tt_sweep_capture #(.LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   mm;
        logic         m;
        int           lat;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   sel    = 0;
    int   fmode  = 0;
    logic         start_v = 1'b0;
    logic         ready_v = 1'b0;
    logic [127:0] exp_v   = '0;

    // Reference functions: s=1 selects the LAT=3 device, whose f is x6 delayed.
    function automatic logic fref(int s, int m, int i);
        logic [6:0] v;
        v = 7'(i);
        if (s == 1) return v[6];
        case (m)
            0:       return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
            1:       return 1'b0;
            default: return v[0] ^ v[3] ^ v[6];
        endcase
    endfunction

    logic [6:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= b3.x;
        d2 <= d1;
        d3 <= d2;
    end

    assign b0.f        = fref(0, fmode, int'(b0.x));
    assign b3.f        = d3[6];
    assign b0.start    = start_v && (sel == 0);
    assign b3.start    = start_v && (sel == 1);
    assign b0.expected = exp_v;
    assign b3.expected = exp_v;
    assign b0.tt_ready = ready_v;
    assign b3.tt_ready = ready_v;

    logic [6:0]   o_x;
    logic         o_busy, o_valid, o_match;
    logic [127:0] o_tt;
    logic [7:0]   o_mm;
    assign o_x     = (sel == 1) ? b3.x            : b0.x;
    assign o_busy  = (sel == 1) ? b3.busy         : b0.busy;
    assign o_valid = (sel == 1) ? b3.tt_valid     : b0.tt_valid;
    assign o_match = (sel == 1) ? b3.match        : b0.match;
    assign o_tt    = (sel == 1) ? b3.tt_out       : b0.tt_out;
    assign o_mm    = (sel == 1) ? b3.mismatch_cnt : b0.mismatch_cnt;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(int s, int fm, logic [127:0] exp, bit pulse10, int hold_n);
        res_t r;
        int   cyc;
        int   n;
        sel   = s;
        fmode = fm;
        n     = 0;
        for (int i = 0; i < 128; i++) begin
            r.tt[i] = fref(s, fm, i);
            if (r.tt[i] != exp[i]) n++;
        end
        r.mm  = 8'(n);
        r.m   = (n == 0);
        r.lat = (s == 1) ? 132 : 129;
        sb.push_back(r);

        @(negedge clk);
        exp_v   = exp;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        exp_v   = ~exp;
        cyc     = 1;
        chk("busy_after_start", 128'(o_busy), 128'(1));
        while (o_valid !== 1'b1 && cyc < 400) begin
            start_v = pulse10 && (o_x == 7'd10);
            @(negedge clk);
            cyc++;
        end
        start_v = 1'b0;

        r = sb.pop_front();
        chk("tt_valid",     128'(o_valid), 128'(1));
        chk("latency",      128'(cyc),     128'(r.lat));
        chk("tt_out",       o_tt,          r.tt);
        chk("mismatch_cnt", 128'(o_mm),    128'(r.mm));
        chk("match",        128'(o_match), 128'(r.m));

        for (int k = 0; k < hold_n; k++) begin
            start_v = k[0];
            @(negedge clk);
            start_v = 1'b0;
            chk("hold_valid", 128'(o_valid), 128'(1));
            chk("hold_tt",    o_tt,          r.tt);
            chk("hold_mm",    128'(o_mm),    128'(r.mm));
        end

        start_v = 1'b1;
        ready_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        ready_v = 1'b0;
        chk("idle_valid",  128'(o_valid), 128'(0));
        chk("idle_busy",   128'(o_busy),  128'(0));
        chk("idle_match",  128'(o_match), 128'(0));
        chk("idle_x",      128'(o_x),     128'(0));
        chk("idle_tt_ret", o_tt,          r.tt);
        chk("idle_mm_ret", 128'(o_mm),    128'(r.mm));
        repeat (3) @(negedge clk);
        chk("no_restart",  128'(o_busy),  128'(0));
    endtask

    initial begin
        int t;
        int seen;
        logic [127:0] rnd;
        rst = 1'b1;
        #12;
        sel = 0;
        chk("rst_busy",  128'(o_busy),  128'(0));
        chk("rst_x",     128'(o_x),     128'(0));
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_match", 128'(o_match), 128'(0));
        chk("rst_mm",    128'(o_mm),    128'(0));
        chk("rst_tt",    o_tt,          128'(0));
        sel = 1;
        #1;
        chk("rst3_busy", 128'(o_busy), 128'(0));
        chk("rst3_tt",   o_tt,         128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        sweep(0, 0, {16{8'hE8}}, 1'b0, 0);
        sweep(1, 0, '0, 1'b0, 0);
        sweep(0, 1, '1, 1'b0, 20);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        sweep(0, 2, rnd, 1'b1, 0);

        // Abort a sweep with reset while x=60.
        sel   = 0;
        fmode = 2;
        @(negedge clk);
        exp_v   = '0;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        t = 0;
        while (o_x !== 7'd60 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("reach_x60", 128'(o_x), 128'(60));
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 128'(o_busy),  128'(0));
        chk("abort_x",    128'(o_x),     128'(0));
        chk("abort_tt",   o_tt,          128'(0));
        chk("abort_mm",   128'(o_mm),    128'(0));
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_valid !== 1'b0 || o_busy !== 1'b0) seen++;
        end
        chk("no_result_after_abort", 128'(seen), 128'(0));
        chk("tt_still_clear",        o_tt,       128'(0));

        rnd = {$urandom, $urandom, $urandom, $urandom};
        sweep(0, 0, rnd, 1'b0, 0);
        sweep(1, 0, rnd, 1'b0, 2);
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
